rom_bank_reader: RTL and testbench
==================================

Name: rom_bank_reader

Overview:
- Parametrised multi-bank weight/constant ROM read engine for the accelerator datapath.
- Accepts read requests, each carrying a bank select and an address, over a valid/ready handshake.
- Issues each request to NUM_BANKS synchronous ROM banks and tracks which bank answers through the ROM latency.
- Returns the selected word through an output FIFO with backpressure, so that full-throughput streaming of one read per clock is possible.

Parameters:
- NUM_BANKS, 2, number of ROM banks (1..15)
- DATA_W, 256, ROM word width in bits
- ADDR_W, 13, ROM address width per bank
- SEL_W, 4, bank-select field width
- ROM_LAT, 2, ROM read latency in cycles from address to douta (>=1)
- FIFO_DEPTH, 4, response FIFO entries (power of 2, >= ROM_LAT+1)

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  read request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_sel  in  SEL_W  bank select; value k in 1..NUM_BANKS selects bank k-1
- req_addr  in  ADDR_W  word address within the bank
- resp_valid  out  1  response word available
- resp_ready  in  1  consumer accepts the response
- resp_data  out  DATA_W  read word; zero for invalid select
- resp_err  out  1  response came from an out-of-range select (0 or >NUM_BANKS)
- busy  out  1  any read in flight or buffered

Behaviour:
- Reset (async, rst=1):
  - FIFO pointers, occupancy, credit counter and latency pipeline all clear.
  - Outputs: req_ready=0, resp_valid=0, resp_data=0, resp_err=0, busy=0.
  - req_ready rises on the first clk edge after rst deasserts.
  - Reset mid-operation discards all in-flight and buffered reads; no response is ever produced for them.
- Credits:
  - credits = FIFO_DEPTH - (FIFO occupancy + reads in flight).
  - req_ready = (credits != 0) & ~in_reset.
  - An accepted request decrements credits and a FIFO pop increments them; if both happen in the same cycle, credits are unchanged.
- Issue on accept:
  - Bank s-1 gets ena=1 with addra=req_addr.
  - All other banks get ena=0 (power gating).
  - Invalid select enables no bank.
- Tracking pipeline: a ROM_LAT-stage shift register of {valid, sel_idx, err} follows each request.
- Capture: at stage ROM_LAT, the word is muxed from the tracked bank (zero when err) and pushed into the FIFO in the same cycle.
  - Latency from accept to resp_valid is ROM_LAT+1 cycles when the FIFO is empty.
- FIFO and response outputs:
  - FIFO is first-word-fall-through; resp_data and resp_err are registered FIFO-head outputs.
  - Responses are returned strictly in request order.
  - A pop occurs on resp_valid & resp_ready.
  - When the FIFO is empty, resp_data holds its last value.
- Boundary conditions:
  - Full FIFO plus a push cannot happen, because credits guarantee it; an assertion flags overflow.
  - Simultaneous push and pop on a full FIFO is legal and occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - busy = (occupancy != 0) | any pipeline valid.
- Back-to-back streaming:
  - With resp_ready held at 1, one request is accepted per cycle indefinitely.
  - With resp_ready=0, exactly FIFO_DEPTH requests are accepted, then req_ready drops.
- Arithmetic widths:
  - Credit counter is clog2(FIFO_DEPTH)+1 bits.
  - sel_idx is SEL_W bits; out-of-range is determined combinationally at accept as (req_sel==0 | req_sel>NUM_BANKS).

Optional Feature:
- Macro: ROM_RD_STATS_EN.
- Defined: adds output port rd_count [31:0], a saturating count of accepted requests, plus output err_count [15:0], a saturating count of err responses popped. Both clear on rst.
- Undefined: neither port nor counter exists, and all other behaviour is identical.

Decomposition:
- Shared package rom_pkg holds:
  - the default constants (DATA_W=256, ADDR_W=13, SEL_W=4, ROM_LAT=2);
  - the typedef of the tracking-stage struct {valid, sel_idx, err};
  - a function sel_is_valid(sel, NUM_BANKS).
- One natural sub-module, rom_resp_fifo: parametrised FWFT FIFO (width DATA_W+1, depth FIFO_DEPTH) with push/pop/full/empty/count.
- ROM banks are a generate loop over vendor IP wrappers; bank i is loaded from init file rom_b<i>.

Test Plan:
- Reset then single read: sel=1, addr=0x0005 with resp_ready=1 -> resp_valid exactly 3 cycles after accept; resp_data = bank0[5]; resp_err=0.
- Invalid select: sel=0 and sel=3 (NUM_BANKS=2) -> resp_data=0 and resp_err=1; no bank ena pulse is observed.
- Streaming: 100 requests alternating sel 1/2 over addresses 0..99 with resp_ready=1 -> req_ready is never low after the first cycle; responses arrive in order and match the model.
- Backpressure: resp_ready=0 with continuous requests -> exactly 4 are accepted, then req_ready=0. Raise resp_ready -> 4 responses drain in order and req_ready returns the cycle after the first pop.
- Reset mid-stream: assert rst with 2 in flight and 2 buffered -> resp_valid=0 and busy=0 immediately. After release, one new read sel=2, addr=7 -> only bank1[7] is returned.
- ROM_RD_STATS_EN build: 10 accepted requests, 3 of them invalid, all drained -> rd_count=10, err_count=3.

Source files
------------

// File: rtl/rom_pkg.sv
// rom_pkg: shared defaults, tracking-stage type and helper
// functions for the rom_bank_reader read engine.
package rom_pkg;

  localparam int DEF_DATA_W  = 256;
  localparam int DEF_ADDR_W  = 13;
  localparam int DEF_SEL_W   = 4;
  localparam int DEF_ROM_LAT = 2;

  // One entry of the latency-tracking shift register.
  typedef struct packed {
    logic                 valid;
    logic [DEF_SEL_W-1:0] sel_idx;
    logic                 err;
  } trk_t;

  // A select k is legal when it names bank k-1 of num_banks.
  function automatic logic sel_is_valid(
    input int sel,
    input int num_banks
  );
    return (sel != 0) && (sel <= num_banks);
  endfunction

  // Word image of bank 'bank' (rom_b<bank>): every 32-bit lane
  // carries a tag, the bank, the lane number and the address.
  function automatic logic [DEF_DATA_W-1:0] rom_word(
    input int                    bank,
    input logic [DEF_ADDR_W-1:0] addr
  );
    logic [DEF_DATA_W-1:0] w;
    w = '0;
    for (int j = 0; j < DEF_DATA_W / 32; j++) begin
      w[j*32 +: 32] = {8'hA5, 4'(bank), 4'(j), 3'b000, addr};
    end
    return w;
  endfunction

endpackage

// File: rtl/rom_resp_fifo.sv
// rom_resp_fifo: first-word-fall-through response FIFO with a
// registered head; count includes the entry shown at the head.
module rom_resp_fifo
  import rom_pkg::*;
#(
  parameter int W     = DEF_DATA_W + 1,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   head_valid,
  output logic [W-1:0]           head_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          bypass;

  // Next occupancy / head slot; bypass when the pushed word
  // becomes the head in the same cycle.
  always_comb begin
    cnt_nxt = count + CW'(push) - CW'(pop);
    rd_nxt  = rd_ptr + AW'(pop);
    bypass  = push && (count == CW'(pop));
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and registered head; the head holds
  // its last value once the FIFO drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      wr_ptr     <= wr_ptr + AW'(push);
      rd_ptr     <= rd_nxt;
      count      <= cnt_nxt;
      head_valid <= (cnt_nxt != '0);
      if (cnt_nxt != '0) begin
        head_data <= bypass ? push_data : mem[rd_nxt];
      end
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/rom_bank_reader.sv
// rom_bank_reader: credit-controlled multi-bank ROM reader.
// Define ROM_RD_STATS_EN to add rd_count / err_count outputs.
module rom_bank_reader
  import rom_pkg::*;
#(
  parameter int NUM_BANKS  = 2,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int SEL_W      = DEF_SEL_W,
  parameter int ROM_LAT    = DEF_ROM_LAT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [SEL_W-1:0]  req_sel,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              busy
`ifdef ROM_RD_STATS_EN
  ,
  output logic [31:0]       rd_count,
  output logic [15:0]       err_count
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 in_reset;
  logic [CW-1:0]        used;
  logic                 accept;
  logic                 pop;
  logic                 sel_ok;
  logic [NUM_BANKS-1:0] bank_ena;
  logic [DATA_W-1:0]    douta [NUM_BANKS];
  trk_t                 trk [ROM_LAT];
  trk_t                 cap;
  logic [DATA_W-1:0]    cap_word;
  logic                 pipe_busy;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_W:0]      head;

  assign sel_ok    = sel_is_valid(int'(req_sel), NUM_BANKS);
  assign req_ready = ~in_reset & (used != CW'(FIFO_DEPTH));
  assign accept    = req_valid & req_ready;
  assign pop       = resp_valid & resp_ready;

  // Hold off requests until the first edge after reset,
  // and track slots taken by in-flight plus buffered reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_reset <= 1'b1;
      used     <= '0;
    end else begin
      in_reset <= 1'b0;
      used     <= used + CW'(accept) - CW'(pop);
    end
  end

  // Only the addressed bank is enabled; bad selects enable none.
  always_comb begin
    bank_ena = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_ena[b] = accept && sel_ok &&
                    (int'(req_sel) == b + 1);
    end
  end

  // Synchronous ROM banks, ROM_LAT cycles address-to-data.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] q [ROM_LAT];

    // Read stage on enable, then fixed output pipeline.
    always_ff @(posedge clk) begin
      if (bank_ena[b]) begin
        q[0] <= DATA_W'(rom_word(b, DEF_ADDR_W'(req_addr)));
      end
      for (int k = 1; k < ROM_LAT; k++) begin
        q[k] <= q[k-1];
      end
    end

    assign douta[b] = q[ROM_LAT-1];
  end

  // Shift {valid, sel_idx, err} alongside each ROM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < ROM_LAT; k++) begin
        trk[k] <= '0;
      end
    end else begin
      trk[0].valid   <= accept;
      trk[0].err     <= ~sel_ok;
      trk[0].sel_idx <= sel_ok ?
        DEF_SEL_W'(req_sel - SEL_W'(1)) : '0;
      for (int k = 1; k < ROM_LAT; k++) begin
        trk[k] <= trk[k-1];
      end
    end
  end

  assign cap = trk[ROM_LAT-1];

  // Pick the answering bank's word; errors return zero.
  always_comb begin
    cap_word = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (!cap.err && (int'(cap.sel_idx) == b)) begin
        cap_word = douta[b];
      end
    end
  end

  // Any tracked read still travelling through the ROMs.
  always_comb begin
    pipe_busy = 1'b0;
    for (int k = 0; k < ROM_LAT; k++) begin
      pipe_busy = pipe_busy | trk[k].valid;
    end
  end

  rom_resp_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (cap.valid),
    .push_data  ({cap.err, cap_word}),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .head_valid (resp_valid),
    .head_data  (head)
  );

  assign resp_err  = head[DATA_W];
  assign resp_data = head[DATA_W-1:0];
  assign busy      = ~fifo_empty | pipe_busy;

`ifdef ROM_RD_STATS_EN
  // Saturating counters of accepted reads and popped errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count  <= '0;
      err_count <= '0;
    end else begin
      if (accept && (rd_count != '1)) begin
        rd_count <= rd_count + 32'd1;
      end
      if (pop && resp_err && (err_count != '1)) begin
        err_count <= err_count + 16'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  // Credits must keep the FIFO from ever overflowing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(fifo_full && cap.valid && !pop));
      assert (fifo_count <= used);
    end
  end
`endif

endmodule

// File: tb/tb_rom_bank_reader.sv
// tb_rom_bank_reader: directed vector table plus hand-written
// sequences for streaming, backpressure, reset and stats.
module tb_rom_bank_reader;

  localparam int NB  = 2;
  localparam int DW  = 256;
  localparam int AW  = 13;
  localparam int SW  = 4;
  localparam int LAT = 2;
  localparam int FD  = 4;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [SW-1:0] req_sel;
  logic [AW-1:0] req_addr;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic          resp_err;
  logic          busy;
`ifdef ROM_RD_STATS_EN
  logic [31:0]   rd_count;
  logic [15:0]   err_count;
`endif

  rom_bank_reader #(
    .NUM_BANKS  (NB),
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .SEL_W      (SW),
    .ROM_LAT    (LAT),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sel    (req_sel),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
`ifdef ROM_RD_STATS_EN
    .rd_count   (rd_count),
    .err_count  (err_count),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          err;
    logic [NB-1:0] ena;
  } vec_t;

  typedef logic [DW:0] ent_t;

  int   n_chk;
  int   n_fail;
  int   n_pop;
  ent_t expq[$];
  vec_t vecs[8];

  function automatic logic [DW-1:0] model_word(
    input int bank, input logic [AW-1:0] addr);
    logic [DW-1:0] w;
    for (int j = 0; j < 8; j++) begin
      w[j*32 +: 32] = {8'hA5, 4'(bank), 4'(j), 3'b000, addr};
    end
    return w;
  endfunction

  task automatic chk(input string name,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock with scoreboard: pop check before the edge,
  // expectation queued for an accepted request.
  task automatic tick(output bit acc, output bit rdy);
    ent_t e;
    logic err;
    #1;
    rdy = req_ready;
    acc = req_valid && req_ready;
    if (resp_valid && resp_ready) begin
      n_pop++;
      if (expq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb.extra: unexpected response %0h", resp_data);
      end else begin
        e = expq.pop_front();
        chk("sb.data", resp_data, e[DW-1:0]);
        chk("sb.err", resp_err, e[DW]);
      end
    end
    if (acc) begin
      err = (req_sel == 0) || (int'(req_sel) > NB);
      expq.push_back({err, err ? '0 :
        model_word(int'(req_sel) - 1, req_addr)});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    bit a;
    bit r;
    int cyc;
    req_valid = 1'b0;
    cyc = 0;
    while (expq.size() != 0 && cyc < 30) begin
      tick(a, r);
      cyc++;
    end
    chk({tag, ".left"}, expq.size(), 0);
  endtask

  task automatic single_read(input string tag,
                             input logic [SW-1:0] sel,
                             input logic [AW-1:0] addr,
                             input logic [DW-1:0] ed,
                             input logic ee,
                             input logic [NB-1:0] eena);
    int lat;
    req_valid  = 1'b1;
    req_sel    = sel;
    req_addr   = addr;
    resp_ready = 1'b1;
    #1;
    chk({tag, ".rdy"}, req_ready, 1'b1);
    chk({tag, ".ena"}, dut.bank_ena, eena);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".lat"}, lat, LAT + 1);
    chk({tag, ".data"}, resp_data, ed);
    chk({tag, ".err"}, resp_err, ee);
    @(posedge clk);
    #1;
    chk({tag, ".valid_after"}, resp_valid, 1'b0);
    chk({tag, ".busy_after"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit rdy;
    int n_acc;
    int stray;
    logic [SW-1:0] spat [10];

    n_chk  = 0;
    n_fail = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_sel    = '0;
    req_addr   = '0;
    resp_ready = 1'b0;

    vecs[0] = '{4'd1, 13'h0005, model_word(0, 13'h0005), 1'b0, 2'b01};
    vecs[1] = '{4'd2, 13'h0005, model_word(1, 13'h0005), 1'b0, 2'b10};
    vecs[2] = '{4'd1, 13'h0000, model_word(0, 13'h0000), 1'b0, 2'b01};
    vecs[3] = '{4'd2, 13'h1FFF, model_word(1, 13'h1FFF), 1'b0, 2'b10};
    vecs[4] = '{4'd0, 13'h0003, '0, 1'b1, 2'b00};
    vecs[5] = '{4'd3, 13'h0007, '0, 1'b1, 2'b00};
    vecs[6] = '{4'd15, 13'h0001, '0, 1'b1, 2'b00};
    vecs[7] = '{4'd1, 13'h0ABC, model_word(0, 13'h0ABC), 1'b0, 2'b01};

    // Reset state.
    @(posedge clk);
    #1;
    chk("rst.req_ready", req_ready, 1'b0);
    chk("rst.resp_valid", resp_valid, 1'b0);
    chk("rst.resp_data", resp_data, '0);
    chk("rst.resp_err", resp_err, 1'b0);
    chk("rst.busy", busy, 1'b0);
    rst = 1'b0;
    #1;
    chk("rel.rdy_before_edge", req_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("rel.rdy_after_edge", req_ready, 1'b1);

    // Directed single reads.
    for (int i = 0; i < 8; i++) begin
      single_read($sformatf("v%0d", i), vecs[i].sel,
                  vecs[i].addr, vecs[i].data,
                  vecs[i].err, vecs[i].ena);
    end

    // Full-rate streaming.
    resp_ready = 1'b1;
    n_pop = 0;
    for (int i = 0; i < 100; i++) begin
      req_valid = 1'b1;
      req_sel   = SW'((i % 2) + 1);
      req_addr  = AW'(i);
      tick(acc, rdy);
      if (i > 0) chk($sformatf("stream.rdy%0d", i), rdy, 1'b1);
    end
    drain("stream");
    chk("stream.pops", n_pop, 100);

    // Backpressure: exactly FD accepted.
    resp_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1;
      req_sel   = SW'((i % 2) + 1);
      req_addr  = AW'(16'h100 + i);
      tick(acc, rdy);
      if (acc) n_acc++;
    end
    req_valid = 1'b0;
    chk("bp.accepted", n_acc, FD);
    chk("bp.rdy_low", req_ready, 1'b0);
    chk("bp.valid", resp_valid, 1'b1);
    resp_ready = 1'b1;
    n_pop = 0;
    tick(acc, rdy);
    chk("bp.rdy_back", req_ready, 1'b1);
    drain("bp");
    chk("bp.pops", n_pop, FD);

    // Reset with 2 in flight and 2 buffered.
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_sel   = 4'd1;
      req_addr  = AW'(i + 32);
      tick(acc, rdy);
    end
    req_valid = 1'b0;
    chk("mid.busy_pre", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid.resp_valid", resp_valid, 1'b0);
    chk("mid.busy", busy, 1'b0);
    chk("mid.req_ready", req_ready, 1'b0);
    expq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid.rdy_before_edge", req_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("mid.rdy_after_edge", req_ready, 1'b1);
    single_read("mid.rd", 4'd2, 13'd7,
                model_word(1, 13'd7), 1'b0, 2'b10);
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) stray++;
    end
    chk("mid.stray", stray, 0);

`ifdef ROM_RD_STATS_EN
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    spat = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd3,
             4'd2, 4'd1, 4'd15, 4'd2, 4'd1};
    resp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1;
      req_sel   = spat[i];
      req_addr  = AW'(i + 200);
      tick(acc, rdy);
    end
    drain("stats");
    @(posedge clk);
    #1;
    chk("stats.rd_count", rd_count, 32'd10);
    chk("stats.err_count", err_count, 16'd3);
`else
    spat[0] = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
